// File: rtl/ram_heap_manager_pkg.sv
// rtl/ram_heap_manager_pkg.sv - shared sizes, record/key types and FSM states for the RAM heap
package ram_heap_manager_pkg;

   localparam int Q_DEPTH = 1024;
   localparam int PTR_WD  = 10;
   localparam int IDX_WD  = PTR_WD + 1;
   localparam int REC_WD  = 48;
   localparam int KEY_MSB = 47;
   localparam int KEY_LSB = 32;
   localparam int KEY_WD  = KEY_MSB - KEY_LSB + 1;

   typedef logic [REC_WD-1:0] rec_t;
   typedef logic [KEY_WD-1:0] key_t;
   typedef logic [IDX_WD-1:0] idx_t;
   typedef logic [PTR_WD-1:0] addr_t;

   typedef enum logic [2:0] {
      IDLE,
      UP_RD,
      UP_CMP,
      DN_RDL,
      DN_RDR,
      DN_CMP,
      LOAD_ROOT
   } heap_state_t;

   function automatic key_t rec_key(input rec_t r);
      return r[KEY_MSB:KEY_LSB];
   endfunction

   // Heap index i (1-based) lives at RAM address i-1.
   function automatic addr_t idx2addr(input idx_t idx);
      idx_t a;
      a = idx - 1'b1;
      return a[PTR_WD-1:0];
   endfunction

endpackage

// File: rtl/ram_heap_manager_if.sv
// rtl/ram_heap_manager_if.sv - push/pop command and min-record status bundle for the RAM heap
interface ram_heap_manager_if;
   import ram_heap_manager_pkg::*;

   logic push_to_ram;
   rec_t record_to_push;
   logic pop_from_ram;
   rec_t min_record;
   logic min_valid;
   logic empty;

   modport master (
      output push_to_ram, record_to_push, pop_from_ram,
      input  min_record, min_valid, empty
   );

   modport slave (
      input  push_to_ram, record_to_push, pop_from_ram,
      output min_record, min_valid, empty
   );

endinterface

// File: rtl/ram_heap_manager_heap_ram.sv
// rtl/ram_heap_manager_heap_ram.sv - simple dual-port record RAM, one write port and one sync read port
module heap_ram
   import ram_heap_manager_pkg::*;
(
   input  logic  clk,
   input  logic  we,
   input  addr_t waddr,
   input  rec_t  wdata,
   input  addr_t raddr,
   output rec_t  rdata
);

   rec_t mem [Q_DEPTH];

   // Same-address read during write returns the new data; the finish step relies on this.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= (we && (waddr == raddr)) ? wdata : mem[raddr];
   end

endmodule

// File: rtl/ram_heap_manager.sv
// rtl/ram_heap_manager.sv - binary min-heap priority queue of 48-bit records held in on-chip RAM
module ram_heap_manager
   import ram_heap_manager_pkg::*;
(
   input  logic               clk,
   input  logic               rst_b,
   ram_heap_manager_if.slave  bus
);

   localparam idx_t ROOT_IDX = idx_t'(1);
   localparam idx_t FULL_CNT = idx_t'(Q_DEPTH);

   heap_state_t state, state_nxt;
   idx_t        count, count_nxt;
   idx_t        cur_idx, cur_idx_nxt;
   rec_t        cur_rec, cur_rec_nxt;
   rec_t        left_rec, left_rec_nxt;
   logic        load_cur, load_cur_nxt;
   rec_t        min_record_q;
   logic        min_valid_q;
   logic        empty_q;
   logic        min_ld;

   logic        ram_we;
   addr_t       ram_waddr;
   rec_t        ram_wdata;
   addr_t       ram_raddr;
   rec_t        ram_rdata;

   logic [IDX_WD:0] lidx;
   logic [IDX_WD:0] ridx;
   idx_t            parent;
   rec_t            cur_now;
   logic            right_ok;
   logic            use_right;
   rec_t            small_rec;
   idx_t            small_idx;

   heap_ram u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (ram_waddr),
      .wdata (ram_wdata),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   assign lidx      = {cur_idx, 1'b0};
   assign ridx      = lidx + 1'b1;
   assign parent    = cur_idx >> 1;
   // On the first sift-down step after a pop, the moved record is still arriving from RAM.
   assign cur_now   = load_cur ? ram_rdata : cur_rec;
   assign right_ok  = (ridx <= {1'b0, count});
   assign use_right = right_ok && (rec_key(ram_rdata) < rec_key(left_rec));
   assign small_rec = use_right ? ram_rdata : left_rec;
   assign small_idx = use_right ? ridx[IDX_WD-1:0] : lidx[IDX_WD-1:0];

   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      cur_idx_nxt  = cur_idx;
      cur_rec_nxt  = cur_rec;
      left_rec_nxt = left_rec;
      load_cur_nxt = 1'b0;
      min_ld       = 1'b0;
      ram_we       = 1'b0;
      ram_waddr    = '0;
      ram_wdata    = cur_now;
      ram_raddr    = '0;

      case (state)
         IDLE: begin
            if (bus.push_to_ram && bus.pop_from_ram && (count != '0)) begin
               cur_rec_nxt = bus.record_to_push;
               cur_idx_nxt = ROOT_IDX;
               state_nxt   = DN_RDL;
            end else if (bus.push_to_ram) begin
               if (count != FULL_CNT) begin
                  ram_we      = 1'b1;
                  ram_waddr   = count[PTR_WD-1:0];
                  ram_wdata   = bus.record_to_push;
                  cur_rec_nxt = bus.record_to_push;
                  cur_idx_nxt = count + 1'b1;
                  count_nxt   = count + 1'b1;
                  state_nxt   = UP_RD;
               end
            end else if (bus.pop_from_ram && (count != '0)) begin
               count_nxt = count - 1'b1;
               if (count != ROOT_IDX) begin
                  ram_raddr    = idx2addr(count);
                  load_cur_nxt = 1'b1;
                  cur_idx_nxt  = ROOT_IDX;
                  state_nxt    = DN_RDL;
               end
            end
         end

         UP_RD: begin
            if (cur_idx == ROOT_IDX) begin
               ram_we    = 1'b1;
               ram_waddr = idx2addr(cur_idx);
               state_nxt = LOAD_ROOT;
            end else begin
               ram_raddr = idx2addr(parent);
               state_nxt = UP_CMP;
            end
         end

         UP_CMP: begin
            ram_we    = 1'b1;
            ram_waddr = idx2addr(cur_idx);
            if (rec_key(cur_rec) < rec_key(ram_rdata)) begin
               ram_wdata   = ram_rdata;
               cur_idx_nxt = parent;
               state_nxt   = UP_RD;
            end else begin
               state_nxt = LOAD_ROOT;
            end
         end

         DN_RDL: begin
            if (load_cur) begin
               cur_rec_nxt = ram_rdata;
            end
            if (lidx > {1'b0, count}) begin
               ram_we    = 1'b1;
               ram_waddr = idx2addr(cur_idx);
               state_nxt = LOAD_ROOT;
            end else begin
               ram_raddr = idx2addr(lidx[IDX_WD-1:0]);
               state_nxt = DN_RDR;
            end
         end

         DN_RDR: begin
            left_rec_nxt = ram_rdata;
            ram_raddr    = idx2addr(ridx[IDX_WD-1:0]);
            state_nxt    = DN_CMP;
         end

         DN_CMP: begin
            ram_we    = 1'b1;
            ram_waddr = idx2addr(cur_idx);
            if (rec_key(small_rec) < rec_key(cur_rec)) begin
               ram_wdata   = small_rec;
               cur_idx_nxt = small_idx;
               state_nxt   = DN_RDL;
            end else begin
               state_nxt = LOAD_ROOT;
            end
         end

         LOAD_ROOT: begin
            min_ld    = 1'b1;
            state_nxt = IDLE;
         end

         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state        <= IDLE;
         count        <= '0;
         cur_idx      <= ROOT_IDX;
         cur_rec      <= '0;
         left_rec     <= '0;
         load_cur     <= 1'b0;
         min_record_q <= '0;
         min_valid_q  <= 1'b0;
         empty_q      <= 1'b1;
      end else begin
         state        <= state_nxt;
         count        <= count_nxt;
         cur_idx      <= cur_idx_nxt;
         cur_rec      <= cur_rec_nxt;
         left_rec     <= left_rec_nxt;
         load_cur     <= load_cur_nxt;
         if (min_ld) begin
            min_record_q <= ram_rdata;
         end
         min_valid_q  <= (state_nxt == IDLE) && (count_nxt != '0);
         empty_q      <= (count_nxt == '0);
      end
   end

   assign bus.min_record = min_record_q;
   assign bus.min_valid  = min_valid_q;
   assign bus.empty      = empty_q;

endmodule

// File: tb/tb_ram_heap_manager.sv
// tb/tb_ram_heap_manager.sv - directed self-checking bench for the RAM min-heap queue
module tb_ram_heap_manager;
   import ram_heap_manager_pkg::*;

   logic clk = 1'b0;
   logic rst_b;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   ram_heap_manager_if bus ();

   ram_heap_manager dut (
      .clk   (clk),
      .rst_b (rst_b),
      .bus   (bus)
   );

   function automatic rec_t mk(input logic [15:0] k);
      return {k, 16'hC0DE, k};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic p, input logic q, input logic [15:0] k);
      bus.push_to_ram    = p;
      bus.pop_from_ram   = q;
      bus.record_to_push = mk(k);
      @(negedge clk);
      bus.push_to_ram    = 1'b0;
      bus.pop_from_ram   = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (!(bus.min_valid || bus.empty) && n < 200) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_settle"}, 64'(bus.min_valid || bus.empty), 64'd1);
   endtask

   task automatic push(input logic [15:0] k);
      send(1'b1, 1'b0, k);
      wait_idle($sformatf("push%0d", k));
   endtask

   task automatic pop_expect(input string tag, input logic [15:0] k);
      check({tag, "_valid"}, 64'(bus.min_valid), 64'd1);
      check({tag, "_key"}, 64'(rec_key(bus.min_record)), 64'(k));
      send(1'b0, 1'b1, 16'd0);
      wait_idle(tag);
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_b              = 1'b0;
      bus.push_to_ram    = 1'b0;
      bus.pop_from_ram   = 1'b0;
      bus.record_to_push = '0;
      do_reset();

      // Reset state, then basic pushes
      check("rst_empty", 64'(bus.empty), 64'd1);
      check("rst_valid", 64'(bus.min_valid), 64'd0);
      check("rst_record", 64'(bus.min_record), 64'd0);
      push(16'd5);
      check("t1_first_key", 64'(rec_key(bus.min_record)), 64'd5);
      push(16'd3);
      push(16'd8);
      check("t1_valid", 64'(bus.min_valid), 64'd1);
      check("t1_key", 64'(rec_key(bus.min_record)), 64'd3);
      check("t1_record", 64'(bus.min_record), 64'(mk(16'd3)));
      check("t1_empty", 64'(bus.empty), 64'd0);

      // Ordered drain of five records
      do_reset();
      push(16'd7); push(16'd2); push(16'd9); push(16'd1); push(16'd4);
      pop_expect("t2_pop1", 16'd1);
      pop_expect("t2_pop2", 16'd2);
      pop_expect("t2_pop3", 16'd4);
      pop_expect("t2_pop4", 16'd7);
      pop_expect("t2_pop5", 16'd9);
      check("t2_empty", 64'(bus.empty), 64'd1);
      check("t2_valid", 64'(bus.min_valid), 64'd0);

      // Simultaneous push and pop replaces the root
      do_reset();
      push(16'd3); push(16'd6);
      send(1'b1, 1'b1, 16'd1);
      check("t3_busy", 64'(bus.min_valid), 64'd0);
      wait_idle("t3_pp");
      pop_expect("t3_pop1", 16'd1);
      pop_expect("t3_pop2", 16'd6);
      check("t3_empty", 64'(bus.empty), 64'd1);

      // Push issued mid-sift is ignored
      do_reset();
      send(1'b1, 1'b0, 16'd20);
      check("t6_busy", 64'(bus.min_valid), 64'd0);
      send(1'b1, 1'b0, 16'd10);
      wait_idle("t6_settle");
      check("t6_key", 64'(rec_key(bus.min_record)), 64'd20);
      pop_expect("t6_pop", 16'd20);
      check("t6_empty", 64'(bus.empty), 64'd1);

      // Asynchronous reset during a sift-down
      do_reset();
      push(16'd5); push(16'd3); push(16'd8); push(16'd1);
      send(1'b0, 1'b1, 16'd0);
      check("t5_empty_before", 64'(bus.empty), 64'd0);
      #1 rst_b = 1'b0;
      #1;
      check("t5_empty", 64'(bus.empty), 64'd1);
      check("t5_valid", 64'(bus.min_valid), 64'd0);
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      push(16'd9);
      check("t5_key", 64'(rec_key(bus.min_record)), 64'd9);
      check("t5_not_empty", 64'(bus.empty), 64'd0);

      // Fill to capacity with descending keys, drop the overflow push, drain in order
      do_reset();
      for (int i = 0; i < Q_DEPTH; i++) begin
         push(16'(2000 - i));
      end
      check("t4_full_key", 64'(rec_key(bus.min_record)), 64'd977);
      send(1'b1, 1'b0, 16'd0);
      check("t4_drop_valid", 64'(bus.min_valid), 64'd1);
      @(negedge clk);
      check("t4_drop_key", 64'(rec_key(bus.min_record)), 64'd977);
      for (int j = 0; j < Q_DEPTH; j++) begin
         pop_expect($sformatf("t4_drain%0d", j), 16'(977 + j));
      end
      check("t4_empty", 64'(bus.empty), 64'd1);
      check("t4_valid", 64'(bus.min_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
